accel_line_formatter: RTL



---
 rtl/accel_line_formatter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/accel_line_formatter.sv
// -----------------------------------------------------------------------------
// accel_line_formatter
//
// Captures one converted X-axis accelerometer sample (sign, integer g, milli-g
// fraction) and streams it as a fixed-format ASCII line, e.g. "+0.500g\r\n",
// one byte at a time to a UART transmitter over a valid/ready handshake.
// The milli-g fraction is split into three decimal digits by repeated
// subtraction (hundreds, then tens), one subtraction per cycle.
//
// Optional feature macro: ACCEL_FMT_HEX_EN
//   defined   : line is "<s><d>.<hhh>g,<XXXX>\r\n" (14 bytes), XXXX = raw_x in
//               uppercase hex, most significant nibble first
//   undefined : line is "<s><d>.<hhh>g\r\n" (9 bytes), raw_x is ignored
//
// Parameters
//   DECIM        : one line is emitted per DECIM strobes seen in IDLE (1..255)
//
// Ports
//   clk          : system clock
//   rst          : synchronous active-high reset
//   sample_valid : one-cycle strobe, new sample on is_minus/g_int/g_frac/raw_x
//   is_minus     : sample sign, 1 = negative
//   g_int        : integer part of |g| (clamped to 9 for display)
//   g_frac       : fraction in milli-g (clamped to 999)
//   raw_x        : raw sample, only used with ACCEL_FMT_HEX_EN
//   tx_data      : ASCII byte to the UART (registered)
//   tx_valid     : tx_data is valid (registered)
//   tx_ready     : UART accepts the byte
//   busy         : high whenever the block is not idle (registered)
//   drop_cnt     : strobes dropped while busy, saturating at 255 (registered)
// -----------------------------------------------------------------------------
module accel_line_formatter #(
    parameter int unsigned DECIM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic        is_minus,
    input  logic [15:0] g_int,
    input  logic [15:0] g_frac,
    input  logic [15:0] raw_x,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

`ifdef ACCEL_FMT_HEX_EN
    localparam logic [3:0] LAST_IDX = 4'd13;
`else
    localparam logic [3:0] LAST_IDX = 4'd8;
`endif

    // Decimation counter wraps when it reaches this value.
    localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV_H = 2'd1,
        ST_CONV_T = 2'd2,
        ST_SEND   = 2'd3
    } state_t;

    state_t      state_r;
    logic [7:0]  dec_cnt_r;
    logic        minus_r;
    logic [3:0]  int_dig_r;
    logic [9:0]  rem_r;
    logic [3:0]  hund_r;
    logic [3:0]  tens_r;
    logic [3:0]  ones_r;
    logic [3:0]  idx_r;
    logic [7:0]  tx_data_r;
    logic        tx_valid_r;
    logic        busy_r;
    logic [7:0]  drop_cnt_r;
    logic [15:0] raw_r;

    // ASCII for a decimal digit 0..9.
    function automatic logic [7:0] ascii_dec(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // ASCII for an uppercase hex nibble.
    function automatic logic [7:0] ascii_hex(input logic [3:0] n);
        logic [7:0] c;
        if (n < 4'd10) begin
            c = 8'h30 + {4'h0, n};
        end else begin
            c = 8'h37 + {4'h0, n};
        end
        return c;
    endfunction

    // Byte at position idx of the output line.
    function automatic logic [7:0] line_byte(
        input logic [3:0]  idx,
        input logic        minus,
        input logic [3:0]  int_dig,
        input logic [3:0]  hund,
        input logic [3:0]  tens,
        input logic [3:0]  ones,
        input logic [15:0] raw
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = minus ? 8'h2D : 8'h2B;
            4'd1:    b = ascii_dec(int_dig);
            4'd2:    b = 8'h2E;
            4'd3:    b = ascii_dec(hund);
            4'd4:    b = ascii_dec(tens);
            4'd5:    b = ascii_dec(ones);
            4'd6:    b = 8'h67;
`ifdef ACCEL_FMT_HEX_EN
            4'd7:    b = 8'h2C;
            4'd8:    b = ascii_hex(raw[15:12]);
            4'd9:    b = ascii_hex(raw[11:8]);
            4'd10:   b = ascii_hex(raw[7:4]);
            4'd11:   b = ascii_hex(raw[3:0]);
            4'd12:   b = 8'h0D;
            4'd13:   b = 8'h0A;
`else
            4'd7:    b = 8'h0D;
            4'd8:    b = 8'h0A;
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

`ifndef ACCEL_FMT_HEX_EN
    // raw_x has no role without the hex suffix.
    logic unused_raw_s;
    assign unused_raw_s = ^{raw_x, raw_r};
`endif

    // Main sequencer: capture, digit conversion and byte streaming.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            dec_cnt_r  <= 8'd0;
            minus_r    <= 1'b0;
            int_dig_r  <= 4'd0;
            rem_r      <= 10'd0;
            hund_r     <= 4'd0;
            tens_r     <= 4'd0;
            ones_r     <= 4'd0;
            idx_r      <= 4'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            raw_r      <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sample_valid) begin
                        if (dec_cnt_r == DECIM_LAST) begin
                            dec_cnt_r <= 8'd0;
                            minus_r   <= is_minus;
                            int_dig_r <= (g_int > 16'd9) ? 4'd9 : g_int[3:0];
                            rem_r     <= (g_frac > 16'd999) ? 10'd999 : g_frac[9:0];
                            raw_r     <= raw_x;
                            hund_r    <= 4'd0;
                            tens_r    <= 4'd0;
                            busy_r    <= 1'b1;
                            state_r   <= ST_CONV_H;
                        end else begin
                            dec_cnt_r <= dec_cnt_r + 8'd1;
                        end
                    end
                end
                ST_CONV_H: begin
                    if (rem_r >= 10'd100) begin
                        rem_r  <= rem_r - 10'd100;
                        hund_r <= hund_r + 4'd1;
                    end else begin
                        state_r <= ST_CONV_T;
                    end
                end
                ST_CONV_T: begin
                    if (rem_r >= 10'd10) begin
                        rem_r  <= rem_r - 10'd10;
                        tens_r <= tens_r + 4'd1;
                    end else begin
                        // Remainder is now the ones digit; present byte 0.
                        ones_r     <= rem_r[3:0];
                        idx_r      <= 4'd0;
                        tx_data_r  <= line_byte(4'd0, minus_r, int_dig_r, hund_r,
                                                tens_r, rem_r[3:0], raw_r);
                        tx_valid_r <= 1'b1;
                        state_r    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // tx_valid is always high here, so tx_ready alone is the accept.
                    if (tx_ready) begin
                        if (idx_r == LAST_IDX) begin
                            tx_valid_r <= 1'b0;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            idx_r     <= idx_r + 4'd1;
                            tx_data_r <= line_byte(idx_r + 4'd1, minus_r, int_dig_r,
                                                   hund_r, tens_r, ones_r, raw_r);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    tx_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Drop counter: any strobe outside IDLE is lost, count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_r <= 8'd0;
        end else if (sample_valid && (state_r != ST_IDLE) && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign drop_cnt = drop_cnt_r;

endmodule
